// File: rtl/logica_cell_pkg.sv
// Shared constants and sweep state type for logica_cell (y = b | (~a & ~c)).
package logica_cell_pkg;

  localparam logic [7:0] TRUTH_TABLE = 8'hCD;
  localparam int         SWEEP_LEN   = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sweep_state_e;

  function automatic logic tt_lookup(input logic [2:0] idx);
    return TRUTH_TABLE[idx];
  endfunction

endpackage

// File: rtl/logica_lane.sv
// Single-bit evaluator of y = b | (~a & ~c); purely combinational, 0-cycle latency, no flow control.
module logica_lane (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  assign y = b | (~a & ~c);

endmodule

// File: rtl/logica_cell.sv
// Lane-parallel y = b | (~a & ~c): y combinational, y_q/out_valid 1 cycle later, no backpressure.
// Optional truth-table self-test sweep built when LOGICA_CELL_SWEEP_EN is defined.
module logica_cell
  import logica_cell_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
`ifdef LOGICA_CELL_SWEEP_EN
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic [2:0]       sweep_idx,
  output logic             sweep_done,
  output logic             sweep_err,
`endif
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] lane_a;
  logic [WIDTH-1:0] lane_b;
  logic [WIDTH-1:0] lane_c;
  logic [WIDTH-1:0] lane_y;
  logic             load;

  logic [WIDTH-1:0] y_q_q;
  logic [WIDTH-1:0] y_q_d;
  logic             out_valid_q;
  logic             out_valid_d;

`ifdef LOGICA_CELL_SWEEP_EN
  localparam logic [2:0] LAST_IDX = 3'(SWEEP_LEN - 1);

  sweep_state_e state_q;
  sweep_state_e state_d;
  logic [2:0]   idx_q;
  logic [2:0]   idx_d;
  logic         err_q;
  logic         err_d;
`endif

  // Sweep owns the lanes while running; external traffic is dropped, not queued.
  always_comb begin
    lane_a = a;
    lane_b = b;
    lane_c = c;
    load   = in_valid;
`ifdef LOGICA_CELL_SWEEP_EN
    if (state_q == RUN) begin
      lane_a = {WIDTH{idx_q[2]}};
      lane_b = {WIDTH{idx_q[1]}};
      lane_c = {WIDTH{idx_q[0]}};
      load   = 1'b0;
    end
`endif
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logica_lane u_lane (
      .a (lane_a[i]),
      .b (lane_b[i]),
      .c (lane_c[i]),
      .y (lane_y[i])
    );
  end

  always_comb begin
    y_q_d       = load ? lane_y : y_q_q;
    out_valid_d = load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      y_q_q       <= y_q_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = lane_y;
  assign y_q       = y_q_q;
  assign out_valid = out_valid_q;

`ifdef LOGICA_CELL_SWEEP_EN
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (sweep_start) begin
          state_d = RUN;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        if (lane_y != {WIDTH{tt_lookup(idx_q)}}) err_d = 1'b1;
        idx_d = idx_q + 3'd1;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign sweep_busy = (state_q == RUN);
  assign sweep_done = (state_q == DONE);
  assign sweep_idx  = idx_q;
  assign sweep_err  = err_q;
`endif

endmodule

// File: tb/tb_logica_cell.sv
// Randomised self-checking bench for logica_cell (WIDTH=4); sweep tests built with LOGICA_CELL_SWEEP_EN.
`timescale 1ns/1ps
module tb_logica_cell;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a, b, c;
  logic [W-1:0] y, y_q;
  logic         out_valid;
`ifdef LOGICA_CELL_SWEEP_EN
  logic         sweep_start;
  logic         sweep_busy;
  logic [2:0]   sweep_idx;
  logic         sweep_done;
  logic         sweep_err;
`endif

  int checks = 0;
  int errors = 0;

  // Function values listed in {a,b,c} order 000..111.
  bit tt_list [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] exp_yq;

  logica_cell #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .a           (a),
    .b           (b),
    .c           (c),
`ifdef LOGICA_CELL_SWEEP_EN
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_idx   (sweep_idx),
    .sweep_done  (sweep_done),
    .sweep_err   (sweep_err),
`endif
    .y           (y),
    .y_q         (y_q),
    .out_valid   (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_y(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                         input logic [W-1:0] rc);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      int k;
      k = (ra[i] ? 4 : 0) + (rb[i] ? 2 : 0) + (rc[i] ? 1 : 0);
      r[i] = tt_list[k];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c = '0;
`ifdef LOGICA_CELL_SWEEP_EN
    sweep_start = 1'b0;
`endif
    exp_yq = '0;
    #12;
    checks++; if (y_q !== 4'b0000) begin errors++; $display("FAIL reset_y_q got=%b exp=0000", y_q); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
`ifdef LOGICA_CELL_SWEEP_EN
    checks++;
    if ({sweep_busy, sweep_idx, sweep_done, sweep_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_sweep got busy=%b idx=%0d done=%b err=%b exp all 0",
               sweep_busy, sweep_idx, sweep_done, sweep_err);
    end
`endif
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_exhaustive();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      logic [W-1:0] e;
      a = {W{k[2]}}; b = {W{k[1]}}; c = {W{k[0]}};
      #10;
      e = {W{tt_list[k]}};
      checks++;
      if (y !== e) begin errors++; $display("FAIL exhaustive_%0d got=%b exp=%b", k, y, e); end
    end
  endtask

  task automatic test_registered();
    tick();
    in_valid = 1'b1; a = '0; b = '0; c = '0;
    tick();
    exp_yq = 4'b1111;
    checks++; if (y_q !== exp_yq) begin errors++; $display("FAIL reg_preload got=%b exp=%b", y_q, exp_yq); end
    a = '0; b = '0; c = '1;
    tick();
    exp_yq = 4'b0000;
    checks++;
    if (y_q !== exp_yq || out_valid !== 1'b1) begin
      errors++; $display("FAIL reg_capture got y_q=%b ov=%b exp y_q=%b ov=1", y_q, out_valid, exp_yq);
    end
    in_valid = 1'b0; a = '0; b = '1; c = '0;
    tick();
    checks++;
    if (y_q !== exp_yq || out_valid !== 1'b0) begin
      errors++; $display("FAIL reg_hold got y_q=%b ov=%b exp y_q=%b ov=0", y_q, out_valid, exp_yq);
    end
  endtask

  task automatic test_lanes();
    a = 4'b1010; b = 4'b0100; c = 4'b0011;
    #1;
    checks++; if (y !== 4'b0100) begin errors++; $display("FAIL lanes got=%b exp=0100", y); end
    tick();
  endtask

  task automatic test_random();
    int n_valid = 0;
    int n_pulse = 0;
    for (int t = 0; t < 300; t++) begin
      logic v;
      logic [W-1:0] ey;
      v = 1'($urandom_range(0, 1));
      in_valid = v;
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      #1;
      ey = ref_y(a, b, c);
      checks++; if (y !== ey) begin errors++; $display("FAIL rand_comb t=%0d got=%b exp=%b", t, y, ey); end
      if (v) begin exp_yq = ey; n_valid++; end
      tick();
      if (out_valid === 1'b1) n_pulse++;
      checks++;
      if (y_q !== exp_yq || out_valid !== v) begin
        errors++;
        $display("FAIL rand_reg t=%0d got y_q=%b ov=%b exp y_q=%b ov=%b", t, y_q, out_valid, exp_yq, v);
      end
    end
    checks++;
    if (n_pulse != n_valid) begin errors++; $display("FAIL rand_pulse_count got=%0d exp=%0d", n_pulse, n_valid); end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 8; t++) begin
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      exp_yq = ref_y(a, b, c);
      tick();
      checks++;
      if (y_q !== exp_yq || out_valid !== 1'b1) begin
        errors++; $display("FAIL b2b t=%0d got y_q=%b ov=%b exp y_q=%b ov=1", t, y_q, out_valid, exp_yq);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; a = '0; b = '0; c = '0;
    tick();
    in_valid = 1'b0;
    checks++; if (y_q !== 4'b1111) begin errors++; $display("FAIL arst_preload got=%b exp=1111", y_q); end
    #2 rst_n = 1'b0;
    #1;
    exp_yq = '0;
    checks++;
    if (y_q !== 4'b0000 || out_valid !== 1'b0) begin
      errors++; $display("FAIL arst_clear got y_q=%b ov=%b exp y_q=0000 ov=0", y_q, out_valid);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

`ifdef LOGICA_CELL_SWEEP_EN
  task automatic test_sweep();
    logic [W-1:0] held;
    held = exp_yq;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (sweep_busy !== 1'b1 || sweep_idx !== 3'(k) || y !== {W{tt_list[k]}} || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL sweep_run k=%0d got busy=%b idx=%0d y=%b ov=%b exp busy=1 idx=%0d y=%b ov=0",
                 k, sweep_busy, sweep_idx, y, out_valid, k, {W{tt_list[k]}});
      end
      tick();
    end
    checks++;
    if (sweep_done !== 1'b1 || sweep_busy !== 1'b0 || sweep_err !== 1'b0 || y_q !== held) begin
      errors++;
      $display("FAIL sweep_done got done=%b busy=%b err=%b y_q=%b exp done=1 busy=0 err=0 y_q=%b",
               sweep_done, sweep_busy, sweep_err, y_q, held);
    end
    tick();
    checks++;
    if (sweep_done !== 1'b0) begin errors++; $display("FAIL sweep_done_pulse got=%b exp=0", sweep_done); end
  endtask

  task automatic test_sweep_robust();
    logic [W-1:0] held;
    int n_done;
    int waited;
    held = exp_yq;
    n_done = 0;
    sweep_start = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; sweep_start = 1'b1;
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      #1;
      checks++;
      if (sweep_idx !== 3'(k) || sweep_busy !== 1'b1 || out_valid !== 1'b0 || y_q !== held) begin
        errors++;
        $display("FAIL sweep_busy_ignore k=%0d got idx=%0d busy=%b ov=%b y_q=%b exp idx=%0d busy=1 ov=0 y_q=%b",
                 k, sweep_idx, sweep_busy, out_valid, y_q, k, held);
      end
      if (k == 7) begin in_valid = 1'b0; sweep_start = 1'b0; end
      tick();
      if (sweep_done === 1'b1) n_done++;
    end
    tick();
    if (sweep_done === 1'b1) n_done++;
    checks++;
    if (n_done != 1 || sweep_busy !== 1'b0) begin
      errors++; $display("FAIL sweep_no_restart got done_pulses=%0d busy=%b exp 1 busy=0", n_done, sweep_busy);
    end
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    waited = 0;
    while (sweep_idx !== 3'd4 && waited < 20) begin tick(); waited++; end
    checks++;
    if (sweep_idx !== 3'd4) begin errors++; $display("FAIL sweep_wait_idx4 got=%0d exp=4 (timeout)", sweep_idx); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sweep_busy !== 1'b0 || sweep_idx !== 3'd0 || sweep_done !== 1'b0) begin
      errors++; $display("FAIL sweep_arst got busy=%b idx=%0d done=%b exp 0 0 0", sweep_busy, sweep_idx, sweep_done);
    end
    exp_yq = '0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (sweep_busy !== 1'b0) begin errors++; $display("FAIL sweep_idle_after_rst got busy=%b exp=0", sweep_busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_exhaustive();
    test_registered();
    test_lanes();
    test_random();
    test_back_to_back();
    test_async_reset();
`ifdef LOGICA_CELL_SWEEP_EN
    test_sweep();
    test_sweep_robust();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logica_cell.md
# logica_cell

Registered, lane-parallel evaluator of the three-input function y = (~a | b) & (b | ~c), equivalently y = b | (~a & ~c). It is a leaf datapath cell for control-decode logic. It provides a combinational result, a one-cycle registered result with a valid strobe, and an optional built-in truth-table self-test.

## Interface
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are `clk` and `rst_n`.
- Parameter `WIDTH`, default 1: number of independent bit lanes. Legal range 1..64.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  qualifies `a`, `b` and `c` for registration.
- `a`, `b`, `c`  input  WIDTH each  operand vectors; bit i of each forms lane i.
- `y`  output  WIDTH  combinational lane result.
- `y_q`  output  WIDTH  registered lane result.
- `out_valid`  output  1  single-cycle strobe marking a new `y_q`.
- Present only with the macro defined:
  - `sweep_start`  input  1
  - `sweep_busy`  output  1
  - `sweep_idx`  output  3
  - `sweep_done`  output  1
  - `sweep_err`  output  1

## Operation
- Per lane i: y[i] = b[i] | (~a[i] & ~c[i]).
- Truth table, indexed by {a,b,c} from 000 to 111: 1,0,1,1,0,0,1,1. Packed as index-bit, this is 8'hCD.
- `y` is purely combinational and has no dependence on `clk`.
- Cycle with `in_valid`=1: on the next edge, `y_q` captures the function of the inputs and `out_valid` goes to 1.
- Cycle with `in_valid`=0: `y_q` holds its value and `out_valid` goes to 0.
- There is no backpressure. Every valid input produces exactly one `out_valid` pulse.

## Timing
- Reset values: `y_q`=0, `out_valid`=0, `sweep_busy`=0, `sweep_idx`=0, `sweep_done`=0, `sweep_err`=0.
- Reset takes effect immediately (asynchronous). Release is synchronous to `clk`.
- `y` latency is 0 cycles. `y_q` and `out_valid` latency is 1 cycle.
- Back-to-back `in_valid` sustains a throughput of one result per cycle.
- Reset asserted mid-operation clears all registers, including an in-flight sweep, within the same cycle.

## Configuration
- Macro: `LOGICA_CELL_SWEEP_EN`.
- Defined: the self-test FSM and the sweep ports exist.
  - States are IDLE, RUN and DONE.
  - IDLE to RUN: `sweep_start`=1. This clears `sweep_err` and sets `sweep_idx`=0.
  - RUN: the datapath inputs are overridden. All lanes are driven with {a,b,c}=`sweep_idx`. Each lane's result is compared against TRUTH_TABLE[`sweep_idx`]. Any mismatch sets `sweep_err`, which is sticky. `sweep_idx` increments every cycle.
  - RUN to DONE: after index 7 is checked, so RUN lasts exactly 8 cycles.
  - DONE: `sweep_done` pulses for 1 cycle, then the FSM returns to IDLE.
  - `sweep_busy`=1 in RUN.
  - While busy: `sweep_start` is ignored, `in_valid` is ignored, `out_valid` stays 0, and `y_q` holds.
- Undefined: the FSM, the sweep ports and the comparator are absent. Datapath behaviour is identical.

## Structure
- Package `logica_cell_pkg` holds:
  - constant TRUTH_TABLE = 8'hCD;
  - the sweep state enum (IDLE, RUN, DONE);
  - constant SWEEP_LEN = 8.
- Sub-module `logica_lane`: a single-bit combinational function, instantiated WIDTH times via generate.
- The top level holds the input mux (external inputs vs sweep), the output registers and the sweep FSM.

## Test plan
- Exhaustive single lane (WIDTH=1): apply the 8 combinations 000..111 with 10 time units each -> `y` = 1,0,1,1,0,0,1,1 in that order.
- Registered path: `in_valid`=1 with a=0, b=0, c=1 -> one cycle later `y_q`=0 and `out_valid`=1. Next cycle `in_valid`=0 -> `out_valid`=0 and `y_q` held.
- Lanes (WIDTH=4): a=4'b1010, b=4'b0100, c=4'b0011 -> `y`=4'b0100.
- Reset: assert `rst_n`=0 mid-stream, asynchronous to `clk`, with `y_q`=1 -> `y_q`=0 and `out_valid`=0 immediately.
- Sweep (macro defined): pulse `sweep_start` -> `sweep_busy` high for 8 cycles, `sweep_idx` runs 0..7, `sweep_done` pulses once, `sweep_err`=0.
- Sweep robustness: assert `sweep_start` and `in_valid` while busy -> no restart and no `out_valid`. Reset at `sweep_idx`=4 -> FSM returns to IDLE and `sweep_busy`=0.
